// File: rtl/ahb3lite_req_master.sv
// ahb3lite_req_master
//   AHB-Lite single-master front end. Accepts a valid/ready request stream,
//   buffers it in a small FIFO and issues pipelined NONSEQ SINGLE transfers.
//   Each completed transfer returns one rsp_valid pulse with rsp_err/rsp_rdata.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (req_ready = !full | pop)
//   req_write/addr/size/wdata  request payload (size in HSIZE encoding)
//   rsp_valid/write/err/rdata  one-cycle completion strobe and status
//   HSEL/HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HWDATA  registered AHB outputs
//   HRDATA/HREADY/HRESP    slave response
//   txn_cnt/err_cnt        saturating statistics, only with AHB_MST_STAT_CNT_EN
//
// Build option
//   AHB_MST_STAT_CNT_EN : adds txn_cnt/err_cnt outputs and their counters.
module ahb3lite_req_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
`ifdef AHB_MST_STAT_CNT_EN
   ,output logic [15:0]       txn_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int         PW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] TR_IDLE  = 2'b00;
    localparam logic [1:0] TR_NSEQ  = 2'b10;

    // AP valid / DP valid encode the pipeline; ERR2 = DP erroring, AP cancelled but kept.
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_PIPE, ST_DATA, ST_ERR2} state_t;

    state_t r_state, w_state_nxt;

    logic              r_fifo_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [2:0]        r_fifo_size  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [FIFO_DEPTH];
    logic [PW:0]       r_wr_ptr, r_rd_ptr;

    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [1:0]        r_htrans;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_ap_wdata;
    logic              r_dp_write;

    logic w_empty, w_full, w_pop, w_push, w_ap_busy, w_dp_busy;
    logic [2:0]        w_head_size;
    logic [ADDR_W-1:0] w_head_addr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    assign w_ap_busy = (r_state == ST_ADDR) || (r_state == ST_PIPE);
    assign w_dp_busy = (r_state == ST_PIPE) || (r_state == ST_DATA) || (r_state == ST_ERR2);

    // In ERR2 the held AP entry is reissued first, so the FIFO head must wait.
    assign w_pop     = HREADY && (r_state != ST_ERR2) && !w_empty;
    assign req_ready = !w_full || w_pop;
    assign w_push    = req_valid && req_ready;

    always_comb begin
        w_head_size = r_fifo_size[r_rd_ptr[PW-1:0]];
        if (w_head_size > MAX_SIZE) w_head_size = MAX_SIZE;
        w_head_addr = r_fifo_addr[r_rd_ptr[PW-1:0]] & ({ADDR_W{1'b1}} << w_head_size);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (HREADY) begin
            if (r_state == ST_ERR2) begin
                w_state_nxt = ST_ADDR;
            end else begin
                case ({!w_empty, w_ap_busy})
                    2'b11:   w_state_nxt = ST_PIPE;
                    2'b10:   w_state_nxt = ST_ADDR;
                    2'b01:   w_state_nxt = ST_DATA;
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end else if ((r_state == ST_PIPE) && HRESP) begin
            w_state_nxt = ST_ERR2;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FIFO storage needs no reset; only the pointers define occupancy.
    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr[PW-1:0]] <= req_write;
            r_fifo_addr [r_wr_ptr[PW-1:0]] <= req_addr;
            r_fifo_size [r_wr_ptr[PW-1:0]] <= req_size;
            r_fifo_wdata[r_wr_ptr[PW-1:0]] <= req_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= '0;
            r_htrans   <= TR_IDLE;
            r_hwdata   <= '0;
            r_ap_wdata <= '0;
            r_dp_write <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_htrans <= ((w_state_nxt == ST_ADDR) || (w_state_nxt == ST_PIPE)) ? TR_NSEQ : TR_IDLE;
            if (HREADY) begin
                rsp_valid <= w_dp_busy;
                rsp_write <= w_dp_busy && r_dp_write;
                rsp_err   <= w_dp_busy && HRESP;
                rsp_rdata <= (w_dp_busy && !r_dp_write && !HRESP) ? HRDATA : '0;
                if (w_ap_busy) begin
                    r_dp_write <= r_hwrite;
                    r_hwdata   <= r_ap_wdata;
                end
                if (w_pop) begin
                    r_haddr    <= w_head_addr;
                    r_hwrite   <= r_fifo_write[r_rd_ptr[PW-1:0]];
                    r_hsize    <= w_head_size;
                    r_ap_wdata <= r_fifo_wdata[r_rd_ptr[PW-1:0]];
                end
            end else begin
                rsp_valid <= 1'b0;
                rsp_write <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    assign HADDR  = r_haddr;
    assign HWRITE = r_hwrite;
    assign HSIZE  = r_hsize;
    assign HTRANS = r_htrans;
    assign HSEL   = (r_htrans != TR_IDLE);
    assign HWDATA = r_hwdata;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

`ifdef AHB_MST_STAT_CNT_EN
    logic [15:0] r_txn_cnt, r_err_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_txn_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (rsp_valid && (r_txn_cnt != 16'hFFFF))            r_txn_cnt <= r_txn_cnt + 16'd1;
            if (rsp_valid && rsp_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign txn_cnt = r_txn_cnt;
    assign err_cnt = r_err_cnt;
`endif

endmodule
